// File: rtl/cmp_pkg.sv
// Shared types and constants for the magnitude comparator slice.
// Optional feature macro: MAG_CMP_SIGNED_EN (two's complement operands).
package cmp_pkg;

    // One-hot ordering flag as produced by a single cell or a whole word
    typedef struct packed {
        logic lt;
        logic eq;
        logic gt;
    } cmp_res_t;

    // Output state after reset: the only legal non-one-hot result
    localparam cmp_res_t CMP_RES_RESET = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

    // Cascade value for an unchained instance: "everything below is equal"
    localparam cmp_res_t CMP_CASC_IDLE = '{lt: 1'b0, eq: 1'b1, gt: 1'b0};

    // Compile-time signedness switch, consumed by the MSB bit cell
`ifdef MAG_CMP_SIGNED_EN
    localparam bit CMP_SIGNED_EN = 1'b1;
`else
    localparam bit CMP_SIGNED_EN = 1'b0;
`endif

    // True when exactly one of the three flags is set
    function automatic logic cmp_is_one_hot(input cmp_res_t r);
        return (r.lt ^ r.eq ^ r.gt) & ~(r.lt & r.eq & r.gt);
    endfunction

endpackage

// File: rtl/cmp_bit_cell.sv
// Single-bit compare cell: purely combinational lt/eq/gt for one bit pair.
// Under MAG_CMP_SIGNED_EN the cell flagged as the sign bit swaps lt and gt,
// because a set sign bit means a smaller two's complement value.
module cmp_bit_cell
    import cmp_pkg::*;
(
    input  logic     a,
    input  logic     b,
    input  logic     msb_signed,
    output cmp_res_t res_o
);

    logic rawLt;
    logic rawGt;
    logic swapSense;

    // Unsigned bit ordering, optionally inverted for the sign bit
    always_comb begin
        rawLt     = ~a & b;
        rawGt     = a & ~b;
        swapSense = msb_signed & CMP_SIGNED_EN;
        res_o.lt  = swapSense ? rawGt : rawLt;
        res_o.gt  = swapSense ? rawLt : rawGt;
        res_o.eq  = ~(rawLt | rawGt);
    end

endmodule

// File: rtl/magnitude_comparator.sv
// Registered N-bit magnitude comparator with cascade inputs.
// One-cycle latency, one comparison per cycle, no backpressure.
// Optional feature macro: MAG_CMP_SIGNED_EN (MSB cell compares as sign bit).
// WIDTH is meant to stay within 1..64.
module magnitude_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             casc_lt,
    input  logic             casc_eq,
    input  logic             casc_gt,
    output logic             out_valid,
    output logic             lt,
    output logic             eq,
    output logic             gt
);

    cmp_res_t cellRes [WIDTH];
    cmp_res_t cascIn;
    cmp_res_t cascNorm;
    cmp_res_t res_d;
    cmp_res_t res_q;
    logic     valid_d;
    logic     valid_q;

    // One cell per bit; only the top cell is told it holds the sign
    for (genvar i = 0; i < WIDTH; i++) begin : gCell
        cmp_bit_cell uCell (
            .a          (a[i]),
            .b          (b[i]),
            .msb_signed (i == WIDTH - 1),
            .res_o      (cellRes[i])
        );
    end

    // Cascade pass-through; a malformed cascade never reports equality
    always_comb begin
        cascIn   = '{lt: casc_lt, eq: casc_eq, gt: casc_gt};
        cascNorm = cascIn;
        if (!cmp_is_one_hot(cascIn)) begin
            cascNorm.eq = 1'b0;
        end
    end

    // Priority chain: walking upward, the highest differing bit wins
    always_comb begin
        res_d   = cascNorm;
        valid_d = in_valid;
        for (int i = 0; i < WIDTH; i++) begin
            if (!cellRes[i].eq) begin
                res_d = cellRes[i];
            end
        end
    end

    // Result registers: capture on in_valid, hold otherwise, async clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_q   <= CMP_RES_RESET;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (in_valid) begin
                res_q <= res_d;
            end
        end
    end

    assign out_valid = valid_q;
    assign lt        = res_q.lt;
    assign eq        = res_q.eq;
    assign gt        = res_q.gt;

endmodule

// File: tb/tb_magnitude_comparator.sv
// Self-checking bench for magnitude_comparator (WIDTH=8).
// Honours MAG_CMP_SIGNED_EN for the expected ordering.
module tb_magnitude_comparator;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         casc_lt;
    logic         casc_eq;
    logic         casc_gt;
    logic         out_valid;
    logic         lt;
    logic         eq;
    logic         gt;

    int errors = 0;
    int checks = 0;
    bit cmpEn  = 1'b0;

    magnitude_comparator #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .casc_lt   (casc_lt),
        .casc_eq   (casc_eq),
        .casc_gt   (casc_gt),
        .out_valid (out_valid),
        .lt        (lt),
        .eq        (eq),
        .gt        (gt)
    );

    always #5 clk = ~clk;

    // Reference ordering from plain arithmetic, returned as {lt,eq,gt}
    function automatic logic [2:0] modelCompare(input logic [W-1:0] x, input logic [W-1:0] y,
                                                input logic cl, input logic ce, input logic cg);
        bit less;
        if (x != y) begin
`ifdef MAG_CMP_SIGNED_EN
            less = $signed(x) < $signed(y);
`else
            less = x < y;
`endif
            return less ? 3'b100 : 3'b001;
        end
        if ((int'(cl) + int'(ce) + int'(cg)) == 1) return {cl, ce, cg};
        return {cl, 1'b0, cg};
    endfunction

    // Expected register state, tracked from the inputs seen at each edge
    logic [2:0] expRes     = 3'b000;
    logic       expValid   = 1'b0;
    bit         expDefined = 1'b1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            expRes     <= 3'b000;
            expValid   <= 1'b0;
            expDefined <= 1'b1;
        end else begin
            expValid <= in_valid;
            if (in_valid) begin
                expRes     <= modelCompare(a, b, casc_lt, casc_eq, casc_gt);
                expDefined <= (a != b) || ((int'(casc_lt) + int'(casc_eq) + int'(casc_gt)) == 1);
            end
        end
    end

    // Every-cycle comparison of the DUT against the model
    always @(negedge clk) begin
        if (cmpEn) begin
            checks++;
            if (out_valid !== expValid) begin
                errors++;
                $display("[TB] FAIL model_valid t=%0t: got %b, expected %b", $time, out_valid, expValid);
            end
            checks++;
            if (expDefined) begin
                if ({lt, eq, gt} !== expRes) begin
                    errors++;
                    $display("[TB] FAIL model_result t=%0t: got lt/eq/gt=%b, expected %b",
                             $time, {lt, eq, gt}, expRes);
                end
            end else if ($isunknown({lt, eq, gt})) begin
                errors++;
                $display("[TB] FAIL no_x t=%0t: got lt/eq/gt=%b, expected known bits", $time, {lt, eq, gt});
            end
        end
    end

    task automatic applyStimulus(input bit v, input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic cl, input logic ce, input logic cg);
        in_valid = v;
        a        = x;
        b        = y;
        casc_lt  = cl;
        casc_eq  = ce;
        casc_gt  = cg;
        @(negedge clk);
    endtask

    task automatic checkOutput(input string name, input bit ev, input bit el, input bit ee, input bit eg);
        checks++;
        if ({out_valid, lt, eq, gt} !== {ev, el, ee, eg}) begin
            errors++;
            $display("[TB] FAIL %s: got valid=%b lt=%b eq=%b gt=%b, expected valid=%b lt=%b eq=%b gt=%b",
                     name, out_valid, lt, eq, gt, ev, el, ee, eg);
        end
    endtask

    task automatic checkModel(input string name, input logic [2:0] got, input logic [2:0] expected);
        checks++;
        if (got !== expected) begin
            errors++;
            $display("[TB] FAIL %s: model gave %b, expected %b", name, got, expected);
        end
    endtask

    initial begin
        // Hand-computed pins on the reference model itself
`ifdef MAG_CMP_SIGNED_EN
        checkModel("model_01_ff", modelCompare(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0), 3'b001);
`else
        checkModel("model_01_ff", modelCompare(8'h01, 8'hFF, 1'b0, 1'b1, 1'b0), 3'b100);
`endif
        checkModel("model_casc_lt", modelCompare(8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0), 3'b100);
        checkModel("model_local_wins", modelCompare(8'h3D, 8'h3C, 1'b1, 1'b0, 1'b0), 3'b001);

        // Reset held with valid operands present: outputs stay cleared
        rst      = 1'b1;
        in_valid = 1'b1;
        a        = 8'h55;
        b        = 8'h00;
        casc_lt  = 1'b0;
        casc_eq  = 1'b1;
        casc_gt  = 1'b0;
        cmpEn    = 1'b1;
        @(negedge clk);
        checkOutput("reset_hold_1", 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        checkOutput("reset_hold_2", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_release", 1'b1, 1'b0, 1'b0, 1'b1);

        // Back-to-back ordering
        applyStimulus(1'b1, 8'h80, 8'h7F, 1'b0, 1'b1, 1'b0);
`ifdef MAG_CMP_SIGNED_EN
        checkOutput("order_80_7f", 1'b1, 1'b1, 1'b0, 1'b0);
`else
        checkOutput("order_80_7f", 1'b1, 1'b0, 1'b0, 1'b1);
`endif
        applyStimulus(1'b1, 8'h01, 8'hFF, 1'b0, 1'b1, 1'b0);
`ifdef MAG_CMP_SIGNED_EN
        checkOutput("order_01_ff", 1'b1, 1'b0, 1'b0, 1'b1);
`else
        checkOutput("order_01_ff", 1'b1, 1'b1, 1'b0, 1'b0);
`endif
        applyStimulus(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0);
        checkOutput("order_eq_a5", 1'b1, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b1, 8'hFF, 8'hFE, 1'b0, 1'b1, 1'b0);
        checkOutput("order_ff_fe", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h00, 8'h01, 1'b0, 1'b1, 1'b0);
        checkOutput("order_lsb", 1'b1, 1'b1, 1'b0, 1'b0);

        // Cascade behaviour
        applyStimulus(1'b1, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b1);
        checkOutput("casc_gt", 1'b1, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b1, 8'h3C, 8'h3C, 1'b1, 1'b0, 1'b0);
        checkOutput("casc_lt", 1'b1, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 8'h3D, 8'h3C, 1'b1, 1'b0, 1'b0);
        checkOutput("casc_override", 1'b1, 1'b0, 1'b0, 1'b1);

        // Hold with in_valid low while operands wander
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 8'(i * 37), 8'(200 - i), 1'b1, 1'b0, 1'b0);
            checkOutput("hold", 1'b0, 1'b0, 1'b0, 1'b1);
        end

        // Async reset pulse between edges while eq is shown
        applyStimulus(1'b1, 8'hA5, 8'hA5, 1'b0, 1'b1, 1'b0);
        checkOutput("pre_async_eq", 1'b1, 1'b0, 1'b1, 1'b0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1 checkOutput("async_reset", 1'b0, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("after_async", 1'b0, 1'b0, 1'b0, 1'b0);

        // Malformed cascade with equal operands: only the no-X rule applies
        applyStimulus(1'b1, 8'h3C, 8'h3C, 1'b1, 1'b1, 1'b0);

        // Random regression with well-formed cascades
        for (int i = 0; i < 10000; i++) begin
            logic [W-1:0] x;
            logic [W-1:0] y;
            logic [1:0]   sel;
            x   = 8'($urandom);
            y   = ($urandom_range(3) == 0) ? x : 8'($urandom);
            sel = 2'($urandom_range(2));
            applyStimulus($urandom_range(9) != 0, x, y, sel == 2'd0, sel == 2'd1, sel == 2'd2);
            if (out_valid) begin
                checks++;
                if ((int'(lt) + int'(eq) + int'(gt)) != 1) begin
                    errors++;
                    $display("[TB] FAIL one_hot t=%0t: got lt/eq/gt=%b, expected exactly one set",
                             $time, {lt, eq, gt});
                end
            end
        end

        cmpEn = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
